partial_product_accumulator: RTL
================================

// Module: partial_product_accumulator
// PURPOSE
//  Consumer end of the split 27x18 multiplier. It accepts the two 45-bit partial products
//  (pp_lo = a*b[8:0] zero-extended; pp_hi = a*b[17:9] signed, pre-shifted <<9). It recombines
//  them into the exact signed product and accumulates products into a dot-product result.
//  Groups are delimited by in_last. Results leave through a registered valid/ready output.
//  Sits between the multiplier array and the result write-back.
// PARAMETERS
//  PP_W      45   width of each partial product and of the recombined product
//  ACC_W     48   accumulator/result width; must be >= PP_W
//  SATURATE  1    1: clamp to signed ACC_W range on overflow; 0: wrap (two's complement)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  pp_lo      in   PP_W   signed low partial product
//  pp_hi      in   PP_W   signed high partial product (already shifted)
//  in_last    in   1      this product closes the current group
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat
//  acc_out    out  ACC_W  completed group sum
//  acc_ovf    out  1      an overflow occurred somewhere in this group (sticky per group)
//  out_valid  out  1      acc_out/acc_ovf valid
//  out_ready  in   1      downstream accepts result
// BEHAVIOUR
//  - Reset (async): out_valid=0, acc_out=0, acc_ovf=0, s1_valid=0, acc=0, first=1.
//  - Global enable: en = !(out_valid && !out_ready). Also in_ready = en (combinational).
//  - Accept: the beat is accepted when in_valid && in_ready. S1 registers pp_lo, pp_hi, in_last and sets s1_valid.
//    With en=1 and no accept, s1_valid<=0. With en=0, all stages hold.
//  - S2 on en && s1_valid: prod = sext(pp_lo+pp_hi) to ACC_W. This is exact; no overflow at PP_W.
//    Then acc_next = (first ? 0 : acc) + prod, and the ovf bit is computed from the signs.
//    SATURATE=1 clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1); SATURATE=0 wraps.
//    grp_ovf = (first ? 0 : grp_ovf) | ovf.
//  - If s1_last: acc_out<=acc_next, acc_ovf<=grp_ovf_next, out_valid<=1, first<=1.
//    Otherwise acc<=acc_next, first<=0.
//  - Output: on en && !(completing group) && out_ready, out_valid<=0.
//    When out_ready and completion occur in the same cycle, the new result loads and out_valid stays 1.
//  - Latency: handshake in cycle t with in_last=1 -> out_valid=1 in cycle t+2. Throughput is 1 beat/cycle while unstalled.
//  - Single-beat group (in_last on first beat): result = that product.
//  - out_valid, acc_out and acc_ovf stay stable while out_valid && !out_ready. No input is accepted while stalled.
//  - Reset mid-group: the partial group is discarded and the next beat starts a new group.
// STRUCTURE
//  - Package pp_acc_pkg: PP_W/ACC_W default localparams; functions sat_max(ACC_W) and sat_min(ACC_W).
//  - One sub-module, sat_add: combinational ACC_W signed adder with SATURATE parameter and ovf output.
//    Everything else (S1 regs, accumulator, output reg, enable) is in the top module.
// TESTING
//  1. a=1000, b=-3: pp_lo=509000, pp_hi=-512000, in_last=1, out_ready=1
//     -> acc_out=-3000, acc_ovf=0, out_valid at t+2 for one cycle.
//  2. Back-to-back group of 5*7, -2*4, 100*100 (last on the 3rd), then 1*1 with last
//     -> results 10027 then 1, on consecutive out_valid pulses with no gap.
//  3. SATURATE=1, ACC_W=48: 16 beats of (-2^26)*(-2^17)=2^43, last on the 16th
//     -> acc_out=2^47-1, acc_ovf=1. Next group 1*1 -> acc_out=1, acc_ovf=0.
//     SATURATE=0 -> acc_out=-2^47, acc_ovf=1.
//  4. Backpressure: complete a group with out_ready=0 -> in_ready=0 the cycle after out_valid.
//     Hold in_valid=1 for 5 cycles: no beat is accepted and acc_out is stable.
//     Raise out_ready -> the held beat is accepted once and no beat is lost or duplicated.
//  5. Assert reset for 1 cycle after 2 beats of a 4-beat group -> all outputs are 0.
//     A following 1-beat group 3*3 gives acc_out=9.
//  6. Random: 10k beats with random lengths, in_valid and out_ready; scoreboard against a
//     reference model of sum(a*b) per group with saturation -> zero mismatches.

Source files
------------

// File: rtl/pp_acc_pkg.sv
// pp_acc_pkg: default widths and signed saturation bounds shared by the accumulator and its adder.
package pp_acc_pkg;
    localparam int PP_W_DEF  = 45;
    localparam int ACC_W_DEF = 48;
    localparam int BOUND_W   = 128;
    function automatic logic [BOUND_W-1:0] sat_max(input int w);
        return (BOUND_W'(1) << (w - 1)) - BOUND_W'(1);
    endfunction
    function automatic logic [BOUND_W-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction
endpackage

// File: rtl/sat_add.sv
// sat_add: combinational signed adder reporting two's-complement overflow, optionally clamping the sum.
module sat_add
    import pp_acc_pkg::*;
#(
    parameter int W        = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o,
    output logic                ovf_o
);
    localparam logic signed [W-1:0] MAX = W'(sat_max(W));
    localparam logic signed [W-1:0] MIN = W'(sat_min(W));
    logic signed [W-1:0] raw;
    assign raw   = a_i + b_i;
    assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
    assign sum_o = (SATURATE && ovf_o) ? (a_i[W-1] ? MIN : MAX) : raw;
endmodule

// File: rtl/partial_product_accumulator.sv
// partial_product_accumulator: recombines split 27x18 partial products and sums them per
// in_last-delimited group, emitting each group total through a registered valid/ready port.
module partial_product_accumulator
    import pp_acc_pkg::*;
#(
    parameter int PP_W     = PP_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [PP_W-1:0]  pp_lo,
    input  logic signed [PP_W-1:0]  pp_hi,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    acc_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic                    en, take, done, ovf, grp_ovf_d;
    logic                    s1_valid_q, s1_last_q, first_q, grp_ovf_q, acc_ovf_q, out_valid_q;
    logic signed [PP_W-1:0]  pp_lo_q, pp_hi_q, pp_sum;
    logic signed [ACC_W-1:0] prod, base, acc_d, acc_q, acc_out_q;

    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en;
    assign take      = in_valid && en;
    assign done      = en && s1_valid_q && s1_last_q;
    // The two partial products always sum to the exact 45-bit product, so no overflow check here.
    assign pp_sum    = pp_lo_q + pp_hi_q;
    assign prod      = ACC_W'(pp_sum);
    assign base      = first_q ? '0 : acc_q;
    assign grp_ovf_d = (!first_q && grp_ovf_q) || ovf;
    assign acc_out   = acc_out_q;
    assign acc_ovf   = acc_ovf_q;
    assign out_valid = out_valid_q;

    sat_add #(.W(ACC_W), .SATURATE(SATURATE)) u_add (
        .a_i  (base),
        .b_i  (prod),
        .sum_o(acc_d),
        .ovf_o(ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            pp_lo_q     <= '0;
            pp_hi_q     <= '0;
            first_q     <= 1'b1;
            acc_q       <= '0;
            grp_ovf_q   <= 1'b0;
            acc_out_q   <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            s1_valid_q <= take;
            if (take) begin
                pp_lo_q   <= pp_lo;
                pp_hi_q   <= pp_hi;
                s1_last_q <= in_last;
            end
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    acc_out_q <= acc_d;
                    acc_ovf_q <= grp_ovf_d;
                    first_q   <= 1'b1;
                end else begin
                    acc_q     <= acc_d;
                    grp_ovf_q <= grp_ovf_d;
                    first_q   <= 1'b0;
                end
            end
            // en implies any held result is consumed now, so only a fresh completion keeps valid high.
            out_valid_q <= done;
        end
    end
endmodule
